pdp_accumulator: RTL



---
 rtl/pdp_accumulator_if.sv | 20 ++
 rtl/pdp_accumulator.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pdp_accumulator_if.sv
// AXI4-Stream style bundle for the PDP accumulator.
// Signals: tvalid, tready, tdata[W-1:0], tlast; master drives data, slave drives ready.
interface pdp_accumulator_if #(
    parameter int W = 32
);
    logic         tvalid;
    logic         tready;
    logic [W-1:0] tdata;
    logic         tlast;

    modport master (
        output tvalid, tdata, tlast,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tlast,
        output tready
    );
endinterface

// File: rtl/pdp_accumulator.sv
// Power-delay-profile accumulator: |x|^2 per bin, summed over 2^AVG_LOG2
// frames in RAM, then streamed out averaged. Ports: ACLK, ARESET (sync,
// active high), s_axis (64-bit complex in), m_axis (32-bit power out),
// FRAME_ERR (sticky), BUSY. Optional macro PDP_PEAK_DETECT_EN adds
// PEAK_VALUE / PEAK_INDEX / PEAK_VALID.
module pdp_accumulator #(
    parameter int FRAME_BITS           = 10,
    parameter int AVG_LOG2             = 4,
    parameter int C_S_AXIS_TDATA_WIDTH = 64,
    parameter int C_M_AXIS_TDATA_WIDTH = 32
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    pdp_accumulator_if.slave       s_axis,
    pdp_accumulator_if.master      m_axis,
    output logic                   FRAME_ERR,
    output logic                   BUSY
`ifdef PDP_PEAK_DETECT_EN
    ,
    output logic [31:0]            PEAK_VALUE,
    output logic [FRAME_BITS-1:0]  PEAK_INDEX,
    output logic                   PEAK_VALID
`endif
);
    localparam int N  = 1 << FRAME_BITS;
    localparam int AW = 32 + AVG_LOG2;
    localparam int FW = AVG_LOG2 + 1;
    localparam logic [FW-1:0] FRAMES = FW'(1 << AVG_LOG2);
    localparam logic [FRAME_BITS-1:0] LAST = FRAME_BITS'(N - 1);

    typedef enum logic [1:0] {CLEAR, ACCUM, DUMP} state_t;

    state_t state_q, state_d;

    logic [FRAME_BITS-1:0] clr_q, idx_q;
    logic [FW-1:0]         frm_q;
    logic [AW-1:0]         mem [N];
    logic [AW-1:0]         rd_q;

    // read-modify-write stage
    logic                  rmw_q, byp_q;
    logic [FRAME_BITS-1:0] wa_q;
    logic [31:0]           p_q;
    logic [AW-1:0]         wd_q;

    // dump pipeline: RAM read -> skid -> output register
    logic [FRAME_BITS:0]   ptr_q;
    logic                  rv_q, sv_q, ov_q;
    logic [FRAME_BITS-1:0] ri_q, si_q, oi_q;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] sk_q, od_q;

    logic signed [15:0] re16, im16;
    logic signed [31:0] re2, im2;
    logic [31:0]        p;
    logic               accept, wrap, fire, last_fire, issue;
    logic [1:0]         occ;
    logic [AW-1:0]      acc_old, acc_sum, wdat;
    logic [FRAME_BITS-1:0] wa, ra;
    logic               we, re;
    logic [31:0]        rdv;

    assign re16 = s_axis.tdata[31:16];
    assign im16 = s_axis.tdata[C_S_AXIS_TDATA_WIDTH-1 -: 16];
    assign re2  = re16 * re16;
    assign im2  = im16 * im16;
    assign p    = unsigned'(re2) + unsigned'(im2);

    assign s_axis.tready = (state_q == ACCUM) && (frm_q != FRAMES);
    assign accept    = s_axis.tvalid && s_axis.tready;
    assign wrap      = (idx_q == LAST) || s_axis.tlast;

    assign m_axis.tvalid = ov_q;
    assign m_axis.tdata  = od_q;
    assign m_axis.tlast  = ov_q && (oi_q == LAST);
    assign fire      = ov_q && m_axis.tready;
    assign last_fire = fire && (oi_q == LAST);

    // Keep at most two beats (output + skid) committed, counting the read
    // in flight, so a stalled consumer never loses a prefetched bin.
    assign occ   = 2'(ov_q) + 2'(sv_q) + 2'(rv_q);
    assign issue = (state_q == DUMP) && !ptr_q[FRAME_BITS]
                   && (occ <= 2'(fire) + 2'd1);

    // Back-to-back hits on one bin (short frame ending at bin 0) read stale
    // RAM, so take the value just written instead.
    assign acc_old = byp_q ? wd_q : rd_q;
    assign acc_sum = acc_old + AW'(p_q);
    assign rdv     = 32'(rd_q >> AVG_LOG2);

    assign BUSY = (state_q != ACCUM);

    always_comb begin
        we   = 1'b0;
        wa   = '0;
        wdat = '0;
        unique case (state_q)
            CLEAR: begin
                we = 1'b1;
                wa = clr_q;
            end
            ACCUM: begin
                we   = rmw_q;
                wa   = wa_q;
                wdat = acc_sum;
            end
            DUMP: begin
                we = issue;
                wa = ptr_q[FRAME_BITS-1:0];
            end
            default: ;
        endcase
    end

    assign re = accept || issue;
    assign ra = accept ? idx_q : ptr_q[FRAME_BITS-1:0];

    // Read-first RAM: DUMP reads a bin and zeroes it on the same edge.
    always_ff @(posedge ACLK) begin
        if (we) mem[wa] <= wdat;
        if (re) rd_q <= mem[ra];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CLEAR: if (clr_q == LAST) state_d = ACCUM;
            ACCUM: if (frm_q == FRAMES && !rmw_q) state_d = DUMP;
            DUMP:  if (last_fire) state_d = ACCUM;
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= CLEAR;
            clr_q     <= '0;
            idx_q     <= '0;
            frm_q     <= '0;
            rmw_q     <= 1'b0;
            byp_q     <= 1'b0;
            wa_q      <= '0;
            p_q       <= '0;
            wd_q      <= '0;
            FRAME_ERR <= 1'b0;
            ptr_q     <= '0;
            rv_q      <= 1'b0;
            sv_q      <= 1'b0;
            ov_q      <= 1'b0;
            ri_q      <= '0;
            si_q      <= '0;
            oi_q      <= '0;
            sk_q      <= '0;
            od_q      <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= (state_q == CLEAR) ? clr_q + 1'b1 : '0;

            rmw_q <= accept;
            byp_q <= accept && rmw_q && (wa_q == idx_q);
            if (rmw_q) wd_q <= acc_sum;
            if (accept) begin
                wa_q  <= idx_q;
                p_q   <= p;
                idx_q <= wrap ? '0 : idx_q + 1'b1;
                if (wrap) frm_q <= frm_q + 1'b1;
                if (s_axis.tlast != (idx_q == LAST)) FRAME_ERR <= 1'b1;
            end

            rv_q <= issue;
            if (issue) begin
                ri_q  <= ptr_q[FRAME_BITS-1:0];
                ptr_q <= ptr_q + 1'b1;
            end

            if (!ov_q || fire) begin
                if (sv_q) begin
                    od_q <= sk_q;
                    oi_q <= si_q;
                    ov_q <= 1'b1;
                    sv_q <= rv_q;
                    sk_q <= rdv;
                    si_q <= ri_q;
                end else if (rv_q) begin
                    od_q <= rdv;
                    oi_q <= ri_q;
                    ov_q <= 1'b1;
                end else begin
                    ov_q <= 1'b0;
                end
            end else if (rv_q) begin
                sk_q <= rdv;
                si_q <= ri_q;
                sv_q <= 1'b1;
            end

            if (last_fire) begin
                frm_q <= '0;
                ptr_q <= '0;
            end
        end
    end

`ifdef PDP_PEAK_DETECT_EN
    logic [31:0]           best_q;
    logic [FRAME_BITS-1:0] bidx_q;
    logic                  better;

    // Strict compare keeps the lowest bin on ties.
    assign better = (oi_q == '0) || (od_q > best_q);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            best_q     <= '0;
            bidx_q     <= '0;
            PEAK_VALUE <= '0;
            PEAK_INDEX <= '0;
            PEAK_VALID <= 1'b0;
        end else begin
            PEAK_VALID <= last_fire;
            if (fire && better) begin
                best_q <= od_q;
                bidx_q <= oi_q;
            end
            if (last_fire) begin
                PEAK_VALUE <= better ? od_q : best_q;
                PEAK_INDEX <= better ? oi_q : bidx_q;
            end
        end
    end
`endif

endmodule
